fetch_pc_unit: RTL and testbench

Fetch-stage program counter and direction-prediction unit for the LC-3b pipeline. Owns the PC register that drives `pc_if` into the BTB and instruction cache. Combines the BTB's `btb_hit` and `branch_address` with a table of 2-bit saturating counters to choose the next PC. Checks each resolved control-flow instruction at WB against its carried prediction and, on a mispredict, flushes the pipeline and redirects fetch.

---
 rtl/fetch_pc_unit.sv | 117 +++++++++++
 tb/tb_fetch_pc_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with BTB + 2-bit counter direction prediction and WB-time redirect.
// Build option: define FETCH_BHT_EN to build the direction counters; otherwise a BTB hit always predicts taken.
module fetch_pc_unit #(
   parameter int unsigned LINES    = 32,
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_if,
   input  logic        btb_hit,
   input  logic [15:0] branch_address,
   output logic [15:0] pc_if,
   output logic        fetch_valid,
   output logic        pred_taken_if,
   output logic [15:0] pred_target_if,
   input  logic        is_valid_inst_wb,
   input  logic        is_branch_wb,
   input  logic [15:0] pc_wb,
   input  logic        taken_wb,
   input  logic [15:0] target_wb,
   input  logic        pred_taken_wb,
   input  logic [15:0] pred_target_wb,
   output logic        flush,
   output logic [15:0] mispredict_count
);

   if (LINES < 2 || LINES > 128 || (LINES & (LINES - 1)) != 0) begin : g_bad_lines
      $error("fetch_pc_unit: LINES must be a power of two in 2..128");
   end

   typedef enum logic {BOOT, RUN} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        run;
   logic        ctr_taken;
   logic        resolve;
   logic        mispredict;
   logic [15:0] correct_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BOOT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == BOOT) state_d = RUN;
   end

   always_comb begin
      run         = (state_q == RUN);
      fetch_valid = run;
   end

`ifdef FETCH_BHT_EN
   localparam int IDX = $clog2(LINES);

   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'd1;
      return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   logic [1:0]     ctr_q [LINES];
   logic [1:0]     ctr_d;
   logic [IDX-1:0] idx_if, idx_wb;

   assign idx_if    = pc_q[IDX:1];
   assign idx_wb    = pc_wb[IDX:1];
   // Reads see the registered table, so a same-index WB update is not visible until next cycle.
   assign ctr_taken = ctr_q[idx_if][1];
   assign ctr_d     = ctr_next(ctr_q[idx_wb], taken_wb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINES; i++) ctr_q[i] <= 2'b01;
      end else if (resolve) begin
         ctr_q[idx_wb] <= ctr_d;
      end
   end
`else
   assign ctr_taken = 1'b1;
`endif

   assign pred_taken_if  = run & btb_hit & ctr_taken;
   assign pred_target_if = pred_taken_if ? branch_address : pc_q + 16'd2;

   assign resolve    = run & is_valid_inst_wb & is_branch_wb;
   assign mispredict = resolve & ((taken_wb != pred_taken_wb) |
                                  (taken_wb & (target_wb != pred_target_wb)));
   assign correct_pc = taken_wb ? target_wb : pc_wb + 16'd2;
   assign flush      = mispredict;

   always_comb begin
      pc_d = pred_target_if;
      if (mispredict)            pc_d = correct_pc;
      else if (state_q == BOOT)  pc_d = PC_RESET;
      else if (stall_if)         pc_d = pc_q;
   end

   assign cnt_d = (mispredict && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= PC_RESET;
         cnt_q <= 16'h0000;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   assign pc_if            = pc_q;
   assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: boot sequencing, prediction, redirect, stall, wrap and saturation.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_if;
   logic        btb_hit;
   logic [15:0] branch_address;
   logic [15:0] pc_if;
   logic        fetch_valid;
   logic        pred_taken_if;
   logic [15:0] pred_target_if;
   logic        is_valid_inst_wb;
   logic        is_branch_wb;
   logic [15:0] pc_wb;
   logic        taken_wb;
   logic [15:0] target_wb;
   logic        pred_taken_wb;
   logic [15:0] pred_target_wb;
   logic        flush;
   logic [15:0] mispredict_count;

   int n_checks = 0;
   int n_errors = 0;

`ifdef FETCH_BHT_EN
   localparam bit BHT = 1'b1;
`else
   localparam bit BHT = 1'b0;
`endif

   fetch_pc_unit #(.LINES(32), .PC_RESET(16'h0000)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_if         (stall_if),
      .btb_hit          (btb_hit),
      .branch_address   (branch_address),
      .pc_if            (pc_if),
      .fetch_valid      (fetch_valid),
      .pred_taken_if    (pred_taken_if),
      .pred_target_if   (pred_target_if),
      .is_valid_inst_wb (is_valid_inst_wb),
      .is_branch_wb     (is_branch_wb),
      .pc_wb            (pc_wb),
      .taken_wb         (taken_wb),
      .target_wb        (target_wb),
      .pred_taken_wb    (pred_taken_wb),
      .pred_target_wb   (pred_target_wb),
      .flush            (flush),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic v, input logic br, input logic [15:0] pc,
                     input logic tk, input logic [15:0] tgt,
                     input logic ptk, input logic [15:0] ptgt);
      is_valid_inst_wb = v;
      is_branch_wb     = br;
      pc_wb            = pc;
      taken_wb         = tk;
      target_wb        = tgt;
      pred_taken_wb    = ptk;
      pred_target_wb   = ptgt;
   endtask

   task automatic wb_idle();
      wb(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
   endtask

   initial begin
      rst_n = 1'b0; stall_if = 1'b0; btb_hit = 1'b0; branch_address = 16'h0000;
      wb_idle();
      #12;
      btb_hit = 1'b1; branch_address = 16'h0040;
      #1;
      check("rst_pc", pc_if, 16'h0000);
      check("rst_fetch_valid", fetch_valid, 0);
      check("rst_pred_taken", pred_taken_if, 0);
      check("rst_flush", flush, 0);
      check("rst_count", mispredict_count, 0);
      btb_hit = 1'b0;

      tick();
      rst_n = 1'b1;
      #1;
      check("boot_fetch_valid", fetch_valid, 0);
      tick();
      check("run_fetch_valid", fetch_valid, 1);
      check("pc_step0", pc_if, 16'h0000);
      tick();
      check("pc_step1", pc_if, 16'h0002);
      tick();
      check("pc_step2", pc_if, 16'h0004);

      // direction mispredict
      wb(1, 1, 16'h0020, 1, 16'h0100, 0, 16'h0000);
      #1;
      check("mp1_flush", flush, 1);
      tick(); wb_idle(); #1;
      check("mp1_pc", pc_if, 16'h0100);
      check("mp1_count", mispredict_count, 1);
      check("mp1_flush_drop", flush, 0);

      wb(1, 1, 16'h0030, 1, 16'h0010, 0, 16'h0000);
      tick(); wb_idle(); #1;
      check("redir_pc", pc_if, 16'h0010);
      check("redir_count", mispredict_count, 2);

      // BTB hit at 0x10, stalled while training the counter
      btb_hit = 1'b1; branch_address = 16'h0040; stall_if = 1'b1;
      #1;
      check("hit_pred_initial", pred_taken_if, BHT ? 0 : 1);
      check("hit_target_initial", pred_target_if, BHT ? 16'h0012 : 16'h0040);
      wb(1, 1, 16'h0010, 1, 16'h0040, 1, 16'h0040);
      #1;
      check("train_flush", flush, 0);
      check("same_idx_pre_update", pred_taken_if, BHT ? 0 : 1);
      tick();
      check("stall_hold_pc", pc_if, 16'h0010);
      check("train1_pred", pred_taken_if, 1);
      tick();
      check("train2_pred", pred_taken_if, 1);
      check("train2_target", pred_target_if, 16'h0040);
      repeat (8) tick();
      check("stall_hold_pc_long", pc_if, 16'h0010);
      wb(1, 1, 16'h0010, 0, 16'h5555, 0, 16'h1234);
      #1;
      check("nt_target_ignored", flush, 0);
      tick();
      check("sat_hi_then_dec", pred_taken_if, 1);
      tick();
      check("dec_to_weak_nt", pred_taken_if, BHT ? 0 : 1);
      tick(); tick();
      wb(1, 1, 16'h0010, 1, 16'h0040, 1, 16'h0040);
      tick(); tick();
      wb_idle(); #1;
      check("sat_lo_then_inc", pred_taken_if, 1);
      check("train_count", mispredict_count, 2);
      stall_if = 1'b0;
      tick();
      check("taken_pc", pc_if, 16'h0040);

      // wrong target, issued while stalled
      btb_hit = 1'b0; stall_if = 1'b1;
      wb(1, 1, 16'h0060, 1, 16'h0300, 1, 16'h0200);
      #1;
      check("tgt_flush", flush, 1);
      tick(); wb_idle(); #1;
      check("tgt_pc_over_stall", pc_if, 16'h0300);
      check("tgt_count", mispredict_count, 3);
      tick();
      check("stall_hold_after_mp", pc_if, 16'h0300);
      stall_if = 1'b0;
      wb(0, 1, 16'h0020, 1, 16'h0100, 0, 16'h0000);
      #1;
      check("invalid_no_flush", flush, 0);
      wb(1, 0, 16'h0020, 1, 16'h0100, 0, 16'h0000);
      #1;
      check("nonbranch_no_flush", flush, 0);
      tick(); wb_idle(); #1;
      check("seq_pc", pc_if, 16'h0302);
      check("seq_count", mispredict_count, 3);

      wb(1, 1, 16'hFFFE, 1, 16'h0080, 0, 16'h0000);
      #1;
      check("ffe_taken_flush", flush, 1);
      tick(); wb_idle(); #1;
      check("ffe_taken_pc", pc_if, 16'h0080);
      wb(1, 1, 16'hFFFE, 0, 16'h9999, 1, 16'h0080);
      #1;
      check("ffe_nt_flush", flush, 1);
      tick(); wb_idle(); #1;
      check("ffe_nt_wrap_pc", pc_if, 16'h0000);
      check("ffe_count", mispredict_count, 5);

      wb(1, 1, 16'h0040, 1, 16'hFFFE, 0, 16'h0000);
      tick(); wb_idle(); #1;
      check("pc_fffe", pc_if, 16'hFFFE);
      check("pred_target_wrap", pred_target_if, 16'h0000);
      tick();
      check("pc_wrap", pc_if, 16'h0000);

      // asynchronous reset mid-stream with a mispredict held at WB
      wb(1, 1, 16'h0020, 1, 16'h0100, 0, 16'h0000);
      tick();
      check("pre_rst_pc", pc_if, 16'h0100);
      check("pre_rst_count", mispredict_count, 7);
      rst_n = 1'b0;
      #1;
      check("async_rst_pc", pc_if, 16'h0000);
      check("async_rst_count", mispredict_count, 0);
      check("async_rst_flush", flush, 0);
      check("async_rst_fv", fetch_valid, 0);
      tick();
      rst_n = 1'b1;
      #1;
      check("boot_resolve_ignored", flush, 0);
      tick();
      check("boot_pc_held", pc_if, 16'h0000);
      check("boot_count_held", mispredict_count, 0);
      check("run_flush", flush, 1);

      repeat (65535) tick();
      check("count_reach_max", mispredict_count, 16'hFFFF);
      repeat (4) tick();
      check("count_saturate", mispredict_count, 16'hFFFF);
      check("sat_pc", pc_if, 16'h0100);
      wb_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
